btn_debounce: RTL and testbench



---
 rtl/btn_debounce_pkg.sv | 14 +
 rtl/btn_debounce_cell.sv | 78 +++++++
 rtl/btn_debounce.sv | 41 ++++
 tb/tb_btn_debounce.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// the default acceptance count (10 ms at 100 MHz).
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    HIGH      = 2'b10,
    WAIT_LOW  = 2'b11
  } state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: 2-flop synchronizer, debounce FSM with non-wrapping counter,
// registered level and single-cycle press pulse.
module btn_debounce_cell
  import btn_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse,
  output logic o_level
);

  localparam int unsigned NB_COUNT = $clog2(DEBOUNCE_CYCLES);
  localparam logic [NB_COUNT-1:0] CNT_LAST = NB_COUNT'(DEBOUNCE_CYCLES - 1);

  logic [1:0]          sync;
  logic                s;
  state_e              state;
  logic [NB_COUNT-1:0] count;

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) sync <= '0;
    else          sync <= {sync[0], i_btn};
  end

  assign s = sync[1];

  // Counter is compared before incrementing, so it tops out at CNT_LAST.
  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE_LOW;
      count   <= '0;
      o_pulse <= 1'b0;
      o_level <= 1'b0;
    end else begin
      o_pulse <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (s) begin
            state <= WAIT_HIGH;
            count <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state <= IDLE_LOW;
          end else if (count == CNT_LAST) begin
            state   <= HIGH;
            o_level <= 1'b1;
            o_pulse <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        HIGH: begin
          if (!s) begin
            state <= WAIT_LOW;
            count <= '0;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state <= HIGH;
          end else if (count == CNT_LAST) begin
            state   <= IDLE_LOW;
            o_level <= 1'b0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE_LOW;
      endcase
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Debounced, edge-detected operand-load buttons for the ALU register bank.
// Define BTN_DEBOUNCE_PRIORITY_EN to pass only the lowest-index pulse per cycle.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned NB_BTN          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              i_rst_n,
  input  logic [NB_BTN-1:0] i_btn,
  output logic [NB_BTN-1:0] o_btn_pulse,
  output logic [NB_BTN-1:0] o_btn_level
);

  logic [NB_BTN-1:0] pulse_raw;

  for (genvar gi = 0; gi < NB_BTN; gi++) begin : g_cell
    btn_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clock  (clock),
      .i_rst_n(i_rst_n),
      .i_btn  (i_btn[gi]),
      .o_pulse(pulse_raw[gi]),
      .o_level(o_btn_level[gi])
    );
  end

`ifdef BTN_DEBOUNCE_PRIORITY_EN
  // x & -x isolates the lowest set bit; masked pulses are simply dropped.
  always_comb begin
    o_btn_pulse = pulse_raw & (~pulse_raw + NB_BTN'(1));
  end
`else
  always_comb begin
    o_btn_pulse = pulse_raw;
  end
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce (NB_BTN=3, DEBOUNCE_CYCLES=4): stimulus
// queues expected pulses with their cycle; a monitor checks every pulse seen.
module tb_btn_debounce;

  localparam int unsigned NB  = 3;
  localparam int unsigned DC  = 4;
  localparam int unsigned LAT = DC + 3;

  typedef struct {
    int unsigned cyc;
    logic [NB-1:0] val;
  } exp_t;

  logic          clock = 1'b0;
  logic          i_rst_n = 1'b1;
  logic [NB-1:0] i_btn = '0;
  logic [NB-1:0] o_btn_pulse;
  logic [NB-1:0] o_btn_level;

  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        q[$];

  btn_debounce #(
    .NB_BTN(NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock      (clock),
    .i_rst_n    (i_rst_n),
    .i_btn      (i_btn),
    .o_btn_pulse(o_btn_pulse),
    .o_btn_level(o_btn_level)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_pulse(input logic [NB-1:0] v);
    exp_t e;
    e.cyc = cyc + LAT;
    e.val = v;
    q.push_back(e);
  endtask

  // Monitor: pops an expectation for every pulse; flags extra or missing ones.
  always @(negedge clock) begin
    exp_t e;
    if (!i_rst_n) begin
      check("pulse_in_reset", 32'(o_btn_pulse), 32'd0);
      check("level_in_reset", 32'(o_btn_level), 32'd0);
    end else if (o_btn_pulse != '0) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", 32'(o_btn_pulse), 32'd0);
      end else begin
        e = q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_value", 32'(o_btn_pulse), 32'(e.val));
      end
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      check("missing_pulse", 32'(o_btn_pulse), 32'(e.val));
    end
  end

  initial begin
    // Reset with all buttons pressed: outputs forced low at once and throughout.
    #1 i_btn = 3'b111;
    i_rst_n = 1'b0;
    #1;
    check("reset_pulse_now", 32'(o_btn_pulse), 32'd0);
    check("reset_level_now", 32'(o_btn_level), 32'd0);
    wait_cyc(4);
    i_btn = '0;
    wait_cyc(2);
    i_rst_n = 1'b1;
    wait_cyc(3);

    // Clean press on button 0, held 20 cycles.
    i_btn[0] = 1'b1;
    expect_pulse(3'b001);
    wait_cyc(LAT - 1);
    check("clean_level_before", 32'(o_btn_level[0]), 32'd0);
    wait_cyc(1);
    check("clean_level_after", 32'(o_btn_level[0]), 32'd1);
    wait_cyc(20 - LAT);
    i_btn[0] = 1'b0;
    wait_cyc(LAT - 1);
    check("clean_rel_before", 32'(o_btn_level[0]), 32'd1);
    wait_cyc(1);
    check("clean_rel_after", 32'(o_btn_level[0]), 32'd0);
    wait_cyc(3);

    // Bounce on button 1: toggling every 2 cycles, then steady high.
    for (int unsigned i = 0; i < 12; i++) begin
      i_btn[1] = ((i / 2) % 2) == 0;
      wait_cyc(1);
    end
    i_btn[1] = 1'b1;
    expect_pulse(3'b010);
    wait_cyc(LAT + 3);
    check("bounce_level", 32'(o_btn_level), 32'b010);
    i_btn[1] = 1'b0;
    wait_cyc(LAT + 3);
    check("bounce_released", 32'(o_btn_level), 32'd0);

    // Glitch of DC cycles rejected, DC+1 accepted.
    i_btn[2] = 1'b1;
    wait_cyc(DC);
    i_btn[2] = 1'b0;
    wait_cyc(LAT + 3);
    check("glitch_level", 32'(o_btn_level), 32'd0);
    i_btn[2] = 1'b1;
    expect_pulse(3'b100);
    wait_cyc(DC + 1);
    i_btn[2] = 1'b0;
    wait_cyc(LAT + 5);
    check("min_press_released", 32'(o_btn_level), 32'd0);

    // Simultaneous press on buttons 0 and 2.
    i_btn = 3'b101;
`ifdef BTN_DEBOUNCE_PRIORITY_EN
    expect_pulse(3'b001);
`else
    expect_pulse(3'b101);
`endif
    wait_cyc(LAT + 3);
    check("simul_level", 32'(o_btn_level), 32'b101);
    i_btn = '0;
    wait_cyc(LAT + 3);
    check("simul_released", 32'(o_btn_level), 32'd0);

    // Reset while button 1 sits in WAIT_HIGH, released while still held.
    i_btn[1] = 1'b1;
    wait_cyc(5);
    i_rst_n = 1'b0;
    #1;
    check("midreset_pulse", 32'(o_btn_pulse), 32'd0);
    wait_cyc(3);
    i_rst_n = 1'b1;
    expect_pulse(3'b010);
    wait_cyc(LAT + 3);
    check("midreset_level", 32'(o_btn_level), 32'b010);

    // Asynchronous reset between clock edges clears an accepted level.
    #2 i_rst_n = 1'b0;
    #1;
    check("async_reset_level", 32'(o_btn_level), 32'd0);
    i_btn = '0;
    wait_cyc(2);
    i_rst_n = 1'b1;
    wait_cyc(LAT + 3);

    check("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
